apb_sram_slave: RTL and testbench

APB_SRAM_SLAVE -- requirements
Module: apb_sram_slave

---
 rtl/apb_sram_slave.sv | 108 ++++++++++
 tb/tb_apb_sram_slave.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/apb_sram_slave.sv
// apb_sram_slave: APB4 SRAM slave with wait states, read-only/secure windows and a saturating error counter
module apb_sram_slave #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int DEPTH = 4096,
  parameter int WAIT_STATES = 0,
  parameter logic [31:0] RO_BASE = 32'h0000_3000,
  parameter logic [31:0] RO_SIZE = 32'h0000_0100,
  parameter logic [31:0] SEC_BASE = 32'h0000_3800,
  parameter logic [31:0] SEC_SIZE = 32'h0000_0800
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic [AW-1:0]   PADDR,
  input  logic [2:0]      PPROT,
  input  logic            PSEL,
  input  logic            PENABLE,
  input  logic            PWRITE,
  input  logic [DW-1:0]   PWDATA,
  input  logic [DW/8-1:0] PSTRB,
  output logic [DW-1:0]   PRDATA,
  output logic            PREADY,
  output logic            PSLVERR,
  output logic [15:0]     ERR_CNT
);
  localparam int BL = $clog2(DW/8);
  localparam int IW = $clog2(DEPTH);
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'(DW/8);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic write_q, write_d;
  logic ns_q, ns_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW/8-1:0] strb_q, strb_d;
  logic [3:0] cnt_q, cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [DW-1:0] mem [DEPTH];
  logic [63:0] a64;
  logic [IW-1:0] idx;
  logic err, done, unused_ok;
  assign a64 = 64'(addr_q);
  assign idx = addr_q[IW+BL-1:BL];
  assign err = a64 >= MEM_BYTES || addr_q[BL-1:0] != '0
    || (write_q && a64 >= 64'(RO_BASE) && a64 < 64'(RO_BASE) + 64'(RO_SIZE))
    || (ns_q && a64 >= 64'(SEC_BASE) && a64 < 64'(SEC_BASE) + 64'(SEC_SIZE));
  assign PREADY = state_q == ACCESS && cnt_q == '0;
  assign done = PREADY && PSEL && PENABLE;
  assign PSLVERR = PREADY && err;
  assign PRDATA = PREADY && !write_q && !err ? mem[idx] : '0;
  assign ERR_CNT = err_cnt_q;
  assign unused_ok = ^{PPROT[2], PPROT[0]};
  // Bus inputs are only sampled in the setup cycle; the captured copies drive the whole access.
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    write_d = write_q;
    ns_d = ns_q;
    wdata_d = wdata_q;
    strb_d = strb_q;
    cnt_d = cnt_q;
    err_cnt_d = done && err && err_cnt_q != 16'hFFFF ? err_cnt_q + 16'd1 : err_cnt_q;
    if (state_q == IDLE) begin
      if (PSEL && !PENABLE) begin
        state_d = ACCESS;
        addr_d = PADDR;
        write_d = PWRITE;
        ns_d = PPROT[1];
        wdata_d = PWDATA;
        strb_d = PSTRB;
        cnt_d = WS;
      end
    end else if (!PSEL || done) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q != '0 ? cnt_q - 4'd1 : cnt_q;
    end
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      addr_q <= '0;
      write_q <= 1'b0;
      ns_q <= 1'b0;
      wdata_q <= '0;
      strb_q <= '0;
      cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      write_q <= write_d;
      ns_q <= ns_d;
      wdata_q <= wdata_d;
      strb_q <= strb_d;
      cnt_q <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  // Storage has no reset; writes only land on a clean completion.
  always_ff @(posedge PCLK) begin
    if (done && write_q && !err)
      for (int i = 0; i < DW/8; i++)
        if (strb_q[i]) mem[idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
  end
endmodule

// File: tb/tb_apb_sram_slave.sv
// tb_apb_sram_slave: directed scoreboard bench for two apb_sram_slave instances (2 and 3 wait states)
module tb_apb_sram_slave;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] paddr, pwdata;
  logic [2:0] pprot;
  logic [1:0] psel;
  logic penable, pwrite;
  logic [3:0] pstrb;
  logic [1:0][31:0] prdata;
  logic [1:0] pready, pslverr;
  logic [1:0][15:0] err_cnt;
  int checks = 0;
  int errors = 0;
  int ws_exp [2] = '{2, 3};
  logic [15:0] errcnt_exp [2] = '{16'd0, 16'd0};
  typedef struct {
    string tag;
    logic [31:0] rdata;
    logic err;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  apb_sram_slave #(.WAIT_STATES(2)) dut2 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PPROT(pprot), .PSEL(psel[0]),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .ERR_CNT(err_cnt[0])
  );
  apb_sram_slave #(.WAIT_STATES(3)) dut3 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PPROT(pprot), .PSEL(psel[1]),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .ERR_CNT(err_cnt[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot, input logic [31:0] exp_rd,
                      input logic exp_err, input string tag);
    exp_t e;
    int waits;
    @(negedge clk);
    check({tag, "_errcnt_before"}, 64'(err_cnt[d]), 64'(errcnt_exp[d]));
    psel = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = addr;
    pwdata = data;
    pstrb = strb;
    pprot = prot;
    sb.push_back('{tag, exp_rd, exp_err});
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    while (!pready[d] && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    e = sb.pop_front();
    check({e.tag, "_waits"}, 64'(waits), 64'(ws_exp[d]));
    check({e.tag, "_pready"}, 64'(pready[d]), 64'd1);
    check({e.tag, "_pslverr"}, 64'(pslverr[d]), 64'(e.err));
    check({e.tag, "_prdata"}, 64'(prdata[d]), 64'(e.rdata));
    if (e.err) errcnt_exp[d]++;
  endtask

  task automatic idle();
    @(negedge clk);
    psel = '0;
    penable = 1'b0;
    check("idle_errcnt0", 64'(err_cnt[0]), 64'(errcnt_exp[0]));
    check("idle_errcnt1", 64'(err_cnt[1]), 64'(errcnt_exp[1]));
  endtask

  initial begin
    rst_n = 1'b0;
    psel = '0;
    penable = 1'b0;
    pwrite = 1'b0;
    paddr = '0;
    pwdata = '0;
    pstrb = '0;
    pprot = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_pready", 64'(pready[d]), 64'd0);
      check("rst_pslverr", 64'(pslverr[d]), 64'd0);
      check("rst_prdata", 64'(prdata[d]), 64'd0);
      check("rst_errcnt", 64'(err_cnt[d]), 64'd0);
    end
    rst_n = 1'b1;
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0, 1'b0, "wr10");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 32'hDEADBEEF, 1'b0, "rd10");
    xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 3'b000, 32'h0, 1'b0, "pre20");
    xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 3'b000, 32'h0, 1'b0, "wr20_strb");
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h3, 3'b000, 32'h11BB33DD, 1'b0, "rd20");
    xfer(0, 1'b1, 32'h3800, 32'h5EC00001, 4'hF, 3'b000, 32'h0, 1'b0, "wr3800_sec");
    idle();
    xfer(0, 1'b1, 32'h3000, 32'h0BADF00D, 4'hF, 3'b000, 32'h0, 1'b1, "wr_ro");
    xfer(0, 1'b0, 32'h4000, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, "rd_oor");
    xfer(0, 1'b0, 32'h0002, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, "rd_mis");
    xfer(0, 1'b0, 32'h3800, 32'h0, 4'h0, 3'b010, 32'h0, 1'b1, "rd_sec_ns");
    xfer(0, 1'b0, 32'h3800, 32'h0, 4'h0, 3'b000, 32'h5EC00001, 1'b0, "rd_sec_s");
    xfer(0, 1'b1, 32'h0022, 32'hFFFFFFFF, 4'hF, 3'b000, 32'h0, 1'b1, "wr_mis");
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, 32'h11BB33DD, 1'b0, "rd20_keep");
    @(negedge clk);
    psel = 2'b01;
    penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("viol_pready", 64'(pready[0]), 64'd0);
    end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 32'hDEADBEEF, 1'b0, "rd10_after_viol");
    idle();
    xfer(1, 1'b1, 32'h40, 32'h12345678, 4'hF, 3'b000, 32'h0, 1'b0, "wr40");
    idle();
    @(negedge clk);
    psel = 2'b10;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 32'h40;
    pwdata = 32'hFFFFFFFF;
    pstrb = 4'hF;
    pprot = 3'b000;
    @(negedge clk);
    penable = 1'b1;
    check("abort_pready_a", 64'(pready[1]), 64'd0);
    @(negedge clk);
    check("abort_pready_b", 64'(pready[1]), 64'd0);
    psel = '0;
    penable = 1'b0;
    @(negedge clk);
    check("abort_pready_c", 64'(pready[1]), 64'd0);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, 32'h12345678, 1'b0, "rd40_after_abort");
    xfer(1, 1'b1, 32'h50, 32'hCAFEF00D, 4'hF, 3'b000, 32'h0, 1'b0, "wr50");
    xfer(1, 1'b0, 32'h4000, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, "rd_oor3");
    @(negedge clk);
    check("pre_rst_errcnt", 64'(err_cnt[1]), 64'(errcnt_exp[1]));
    psel = 2'b10;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 32'h50;
    pwdata = 32'h0;
    pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    psel = '0;
    penable = 1'b0;
    #1;
    check("midrst_pready", 64'(pready[1]), 64'd0);
    check("midrst_pslverr", 64'(pslverr[1]), 64'd0);
    check("midrst_prdata", 64'(prdata[1]), 64'd0);
    check("midrst_errcnt3", 64'(err_cnt[1]), 64'd0);
    check("midrst_errcnt2", 64'(err_cnt[0]), 64'd0);
    errcnt_exp[0] = 16'd0;
    errcnt_exp[1] = 16'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 1'b0, 32'h50, 32'h0, 4'h0, 3'b000, 32'hCAFEF00D, 1'b0, "rd50_after_rst");
    xfer(1, 1'b1, 32'h50, 32'h5A5A5A5A, 4'hF, 3'b000, 32'h0, 1'b0, "wr50_after_rst");
    xfer(1, 1'b0, 32'h50, 32'h0, 4'h0, 3'b000, 32'h5A5A5A5A, 1'b0, "rd50_roundtrip");
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
